// File: rtl/trace_capture_if.sv
// Bus bundle between trace_capture and its host: write-event feed, capture
// control, status and the indexed readout port.
interface trace_capture_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic              ev_valid;
    logic              ev_kind;
    logic [ADDR_W-1:0] ev_addr;
    logic [DATA_W-1:0] ev_data;
    logic              arm;
    logic              mode;
    logic              trig_en;
    logic              trig_kind;
    logic [ADDR_W-1:0] trig_addr;
    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              rd_en;
    logic [IW-1:0]     rd_idx;
    logic              rd_valid;
    logic              rd_kind;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [TS_W-1:0]   rd_time;

    modport slave (
        input  ev_valid, ev_kind, ev_addr, ev_data, arm, mode,
        input  trig_en, trig_kind, trig_addr, rd_en, rd_idx,
        output state, count, overflow,
        output rd_valid, rd_kind, rd_addr, rd_data, rd_time
    );

    modport master (
        output ev_valid, ev_kind, ev_addr, ev_data, arm, mode,
        output trig_en, trig_kind, trig_addr, rd_en, rd_idx,
        input  state, count, overflow,
        input  rd_valid, rd_kind, rd_addr, rd_data, rd_time
    );
endinterface

// File: rtl/trace_capture.sv
// Circular trace recorder for register-file / data-memory write events with
// timestamps, fill-stop or wrap modes, address trigger and indexed readout.
module trace_capture #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 64,
    parameter int TS_W      = 16,
    parameter int POST_TRIG = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    trace_capture_if.slave       bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int EW = TS_W + 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [CW-1:0]     post_q, post_d;
    logic              overflow_q, overflow_d;
    logic              mode_q, mode_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_kind_q, rd_kind_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [TS_W-1:0]   rd_time_q, rd_time_d;
    logic [EW-1:0]     mem_q [DEPTH];

    logic              capturing_s, full_s, fill_last_s, trig_hit_s, wr_en_s;
    logic [EW-1:0]     wr_entry_s, rd_entry_s;
    logic [IW-1:0]     rd_slot_s;
    logic              rd_hit_s;

    assign capturing_s = (state_q == ST_CAPTURE) || (state_q == ST_POST);
    assign full_s      = (count_q == CW'(DEPTH));
    assign fill_last_s = !mode_q && (count_q == CW'(DEPTH - 1));
    assign trig_hit_s  = bus.trig_en && bus.ev_valid &&
                         (bus.ev_kind == bus.trig_kind) && (bus.ev_addr == bus.trig_addr);
    // arm wins over any event arriving in the same cycle
    assign wr_en_s     = !bus.arm && capturing_s && bus.ev_valid;
    assign wr_entry_s  = {ts_q, bus.ev_kind, bus.ev_addr, bus.ev_data};
    // once full, the oldest entry sits at the write pointer
    assign rd_slot_s   = full_s ? (wr_ptr_q + bus.rd_idx) : bus.rd_idx;
    assign rd_hit_s    = ({1'b0, bus.rd_idx} < count_q);
    assign rd_entry_s  = mem_q[rd_slot_s];

    // State register and all control/readout flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= {IW{1'b0}};
            count_q    <= {CW{1'b0}};
            ts_q       <= {TS_W{1'b0}};
            post_q     <= {CW{1'b0}};
            overflow_q <= 1'b0;
            mode_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_kind_q  <= 1'b0;
            rd_addr_q  <= {ADDR_W{1'b0}};
            rd_data_q  <= {DATA_W{1'b0}};
            rd_time_q  <= {TS_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ts_q       <= ts_d;
            post_q     <= post_d;
            overflow_q <= overflow_d;
            mode_q     <= mode_d;
            rd_valid_q <= rd_valid_d;
            rd_kind_q  <= rd_kind_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            rd_time_q  <= rd_time_d;
        end
    end

    // Trace RAM write port; contents are deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.arm) begin
            state_d = ST_CAPTURE;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (bus.ev_valid && fill_last_s) begin
                        state_d = ST_DONE;
                    end else if (trig_hit_s) begin
                        state_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_POST: begin
                    if (bus.ev_valid && ((post_q == CW'(1)) || fill_last_s)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Capture datapath and readout
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ts_d       = ts_q;
        post_d     = post_q;
        overflow_d = overflow_q;
        mode_d     = mode_q;
        rd_valid_d = 1'b0;
        rd_kind_d  = rd_kind_q;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        rd_time_d  = rd_time_q;

        if (bus.arm) begin
            wr_ptr_d   = {IW{1'b0}};
            count_d    = {CW{1'b0}};
            ts_d       = {TS_W{1'b0}};
            post_d     = {CW{1'b0}};
            overflow_d = 1'b0;
            mode_d     = bus.mode;
        end else begin
            if (capturing_s && (ts_q != {TS_W{1'b1}})) begin
                ts_d = ts_q + {{(TS_W-1){1'b0}}, 1'b1};
            end else begin
                ts_d = ts_q;
            end
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + {{(IW-1){1'b0}}, 1'b1};
                if (full_s) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                end
                if (state_q == ST_POST) begin
                    post_d = post_q - {{(CW-1){1'b0}}, 1'b1};
                end else if (trig_hit_s) begin
                    post_d = CW'(POST_TRIG);
                end else begin
                    post_d = post_q;
                end
            end else if ((state_q == ST_DONE) && bus.ev_valid) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end

        if (bus.rd_en) begin
            if (rd_hit_s) begin
                rd_valid_d = 1'b1;
                {rd_time_d, rd_kind_d, rd_addr_d, rd_data_d} = rd_entry_s;
            end else begin
                rd_valid_d = 1'b0;
                rd_kind_d  = 1'b0;
                rd_addr_d  = {ADDR_W{1'b0}};
                rd_data_d  = {DATA_W{1'b0}};
                rd_time_d  = {TS_W{1'b0}};
            end
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_kind  = rd_kind_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_time  = rd_time_q;
endmodule
